// File: rtl/io_tile_gen2.sv
// Programmable IO tile: serial config chain with commit validation, plus per-pin
// output-enable and optional registered paths between pad and interconnect.
module io_tile_gen2 #(
  parameter int PINS        = 2,
  parameter int CFG_PER_PIN = 3
) (
  input  logic            clock,
  input  logic            nreset,
  input  logic            config_in,
  output logic            config_out,
  input  logic            config_enable,
  input  logic            config_commit,
  output logic            config_done,
  output logic            config_error,
  input  logic [PINS-1:0] data_from_io,
  output logic [PINS-1:0] data_to_io,
  output logic [PINS-1:0] data_oe,
  input  logic [PINS-1:0] data_from_ic,
  output logic [PINS-1:0] data_to_ic
);

  localparam int CFG_BITS = PINS * CFG_PER_PIN;
  localparam int CNT_W    = $clog2(CFG_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CFG_BITS + 1);

  logic [CFG_BITS-1:0] sr;
  logic [CFG_BITS-1:0] act;
  logic [CNT_W-1:0]    cnt;
  logic [PINS-1:0]     oq;
  logic [PINS-1:0]     iq;
  logic                done_q;
  logic                err_q;
  logic                commit_ok;

  // A commit is only trusted when exactly CFG_BITS bits arrived and no shift is in flight.
  assign commit_ok = config_commit & ~config_enable & (cnt == CNT_FULL);

  always_ff @(posedge clock) begin
    if (!nreset) begin
      sr     <= '0;
      act    <= '0;
      cnt    <= '0;
      oq     <= '0;
      iq     <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      oq     <= data_from_ic;
      iq     <= data_from_io;
      done_q <= 1'b0;
      if (config_enable) begin
        sr <= {sr[CFG_BITS-2:0], config_in};
        if (cnt != CNT_SAT) cnt <= cnt + CNT_W'(1);
      end
      // Any commit request restarts the count, accepted or not.
      if (config_commit) begin
        cnt <= '0;
        if (commit_ok) begin
          act    <= sr;
          done_q <= 1'b1;
          err_q  <= 1'b0;
        end else begin
          err_q  <= 1'b1;
        end
      end
    end
  end

  assign config_out   = sr[CFG_BITS-1];
  assign config_done  = done_q;
  assign config_error = err_q;

  // Per pin: bit0 OE, bit1 registered output, bit2 registered input.
  always_comb begin
    data_oe    = '0;
    data_to_io = '0;
    data_to_ic = '0;
    for (int i = 0; i < PINS; i++) begin
      data_oe[i] = act[CFG_PER_PIN*i];
      if (act[CFG_PER_PIN*i])
        data_to_io[i] = act[CFG_PER_PIN*i+1] ? oq[i] : data_from_ic[i];
      data_to_ic[i] = act[CFG_PER_PIN*i+2] ? iq[i] : data_from_io[i];
    end
  end

endmodule

// File: tb/tb_io_tile_gen2.sv
// Randomized scoreboard bench for io_tile_gen2 (PINS=2) plus a PINS=4 load/commit round-trip.
module tb_io_tile_gen2;
  localparam int P  = 2;
  localparam int CB = 3 * P;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         nreset, config_in, config_enable, config_commit;
  logic         config_out, config_done, config_error;
  logic [P-1:0] data_from_io, data_to_io, data_oe, data_from_ic, data_to_ic;

  io_tile_gen2 #(.PINS(P)) u2 (
    .clock(clock), .nreset(nreset), .config_in(config_in), .config_out(config_out),
    .config_enable(config_enable), .config_commit(config_commit),
    .config_done(config_done), .config_error(config_error),
    .data_from_io(data_from_io), .data_to_io(data_to_io), .data_oe(data_oe),
    .data_from_ic(data_from_ic), .data_to_ic(data_to_ic)
  );

  logic       n4, ci4, co4, ce4, cc4, cd4, cerr4;
  logic [3:0] fio4, tio4, oe4, fic4, tic4;

  io_tile_gen2 #(.PINS(4)) u4 (
    .clock(clock), .nreset(n4), .config_in(ci4), .config_out(co4),
    .config_enable(ce4), .config_commit(cc4),
    .config_done(cd4), .config_error(cerr4),
    .data_from_io(fio4), .data_to_io(tio4), .data_oe(oe4),
    .data_from_ic(fic4), .data_to_ic(tic4)
  );

  typedef struct packed {
    logic         cout, done, err;
    logic [P-1:0] oe, tio, tic;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   active   = 0;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    n_assert++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
    end
  endtask

  // Reference model: the config chain is a bit queue (front = oldest = chain output).
  bit          m_sr[$];
  int          m_cnt;
  bit [CB-1:0] m_act;
  bit [P-1:0]  m_oq, m_iq;
  bit          m_done, m_err;

  function automatic void model_reset();
    m_sr.delete();
    for (int k = 0; k < CB; k++) m_sr.push_back(1'b0);
    m_cnt = 0; m_act = '0; m_oq = '0; m_iq = '0; m_done = 0; m_err = 0;
  endfunction

  function automatic void model_edge();
    bit [CB-1:0] sr_now;
    int          c_old;
    if (!nreset) begin
      model_reset();
      return;
    end
    c_old = m_cnt;
    for (int k = 0; k < CB; k++) sr_now[CB-1-k] = m_sr[k];
    m_oq   = data_from_ic;
    m_iq   = data_from_io;
    m_done = 0;
    if (config_enable) begin
      m_sr.push_back(config_in);
      void'(m_sr.pop_front());
      if (m_cnt < CB + 1) m_cnt++;
    end
    if (config_commit) begin
      if (!config_enable && c_old == CB) begin
        m_act = sr_now; m_done = 1; m_err = 0;
      end else begin
        m_err = 1;
      end
      m_cnt = 0;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.cout = m_sr[0];
    e.done = m_done;
    e.err  = m_err;
    for (int p = 0; p < P; p++) begin
      e.oe[p]  = m_act[3*p];
      e.tio[p] = m_act[3*p] ? (m_act[3*p+1] ? m_oq[p] : data_from_ic[p]) : 1'b0;
      e.tic[p] = m_act[3*p+2] ? m_iq[p] : data_from_io[p];
    end
    return e;
  endfunction

  task automatic step(input bit en, input bit din, input bit cm, input bit nr);
    @(posedge clock);
    model_edge();
    #1;
    config_enable = en; config_in = din; config_commit = cm; nreset = nr;
    data_from_io  = P'($urandom);
    data_from_ic  = P'($urandom);
    sb.push_back(model_out());
    active = 1;
  endtask

  task automatic shift_word(input bit [CB-1:0] w);
    for (int k = CB - 1; k >= 0; k--) step(1, w[k], 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (active) begin
        if (sb.size() == 0) begin
          n_assert++; n_fail++;
          $display("FAIL scoreboard: no expected entry at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("config_out",   config_out,   e.cout);
          chk("config_done",  config_done,  e.done);
          chk("config_error", config_error, e.err);
          chk("data_oe",      data_oe,      e.oe);
          chk("data_to_io",   data_to_io,   e.tio);
          chk("data_to_ic",   data_to_ic,   e.tic);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : driver
    bit [11:0] w4;
    nreset = 0; config_in = 0; config_enable = 0; config_commit = 0;
    data_from_io = '0; data_from_ic = '0;
    n4 = 0; ci4 = 0; ce4 = 0; cc4 = 0; fio4 = 4'b1010; fic4 = 4'hF;
    model_reset();

    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    idle(2);
    // Pin1 OE+registered out, pin0 OE combinational.
    shift_word(6'b011_001);
    step(0, 0, 1, 1);
    idle(6);
    // Under-shift rejection, then a clean load.
    for (int k = 0; k < 5; k++) step(1, 1'($urandom), 0, 1);
    step(0, 0, 1, 1);
    idle(3);
    shift_word(6'($urandom));
    step(0, 0, 1, 1);
    idle(3);
    // Over-shift rejection.
    for (int k = 0; k < 8; k++) step(1, 1'($urandom), 0, 1);
    step(0, 0, 1, 1);
    idle(3);
    // Shift and commit in the same cycle with a full count.
    shift_word(6'b101_101);
    step(1, 1, 1, 1);
    idle(3);
    // Registered input on pin0, then reset mid-stream.
    shift_word(6'b000_101);
    step(0, 0, 1, 1);
    idle(6);
    step(0, 0, 0, 0);
    idle(3);
    // Reset landing on a commit cycle.
    shift_word(6'b111_111);
    step(0, 0, 1, 0);
    idle(3);
    repeat (30) begin
      shift_word(6'($urandom));
      step(0, 0, 1, 1);
      idle($urandom_range(1, 4));
    end
    repeat (400)
      step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) != 0);
    @(negedge clock);
    #1;
    active = 0;

    // PINS=4 round-trip.
    @(posedge clock); #1;
    n4 = 1;
    @(negedge clock);
    chk("p4_reset_oe",   oe4, 4'h0);
    chk("p4_reset_cout", co4, 1'b0);
    w4 = 12'($urandom);
    for (int k = 11; k >= 0; k--) begin
      ce4 = 1; ci4 = w4[k];
      @(posedge clock); #1;
    end
    ce4 = 0; ci4 = 0; cc4 = 1;
    @(posedge clock); #1;
    cc4 = 0;
    chk("p4_done",  cd4,   1'b1);
    chk("p4_error", cerr4, 1'b0);
    chk("p4_oe",    oe4,   {w4[9], w4[6], w4[3], w4[0]});
    chk("p4_to_io", tio4,  {w4[9], w4[6], w4[3], w4[0]});
    chk("p4_to_ic", tic4,  4'b1010);
    @(posedge clock); #1;
    chk("p4_done_pulse", cd4, 1'b0);
    for (int j = 0; j < 12; j++) begin
      chk("p4_chain_out", co4, w4[11-j]);
      ce4 = 1; ci4 = 1'($urandom);
      @(posedge clock); #1;
    end
    ce4 = 0;
    chk("p4_oe_hold", oe4, {w4[9], w4[6], w4[3], w4[0]});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
